// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and helpers for the Sobel window buffer slice.
//   state_t       frame-control FSM states
//   WIN_TL..WIN_BR  window element indices, k = row*3 + col, row 0 = oldest line
//   win_lsb()     bit offset of window element k in a packed 9-element window
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic int win_lsb(input int k, input int pix_w);
    return k * pix_w;
  endfunction

endpackage

// File: rtl/sobel_window_buf_if.sv
// sobel_window_buf_if: pixel-in / window-out streaming handshake.
//   in_valid/in_ready/in_pix        raster-order pixel stream
//   out_valid/out_ready             window handshake
//   out_win                         9 packed pixels, element k at [k*PIX_W +: PIX_W]
//   out_x/out_y                     window centre coordinates
// master = pixel source / window sink, slave = window generator.
interface sobel_window_buf_if #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                 in_valid;
  logic                 in_ready;
  logic [PIX_W-1:0]     in_pix;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*PIX_W-1:0]   out_win;
  logic [XW-1:0]        out_x;
  logic [YW-1:0]        out_y;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_win, out_x, out_y
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_win, out_x, out_y
  );
endinterface

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two line buffers packed into one RAM word per column.
//   clk    rising-edge clock
//   we     write enable
//   addr   column address
//   wdata  {lb1, lb0} to store
//   rdata  {lb1, lb0} at addr, combinational (old contents on a same-cycle write)
// Not reset: the first two rows of every frame overwrite it before it is read
// into a window that is emitted.
module sobel_line_buf #(
  parameter int PIX_W = 4,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [2*PIX_W-1:0] wdata,
  output logic [2*PIX_W-1:0] rdata
);

  logic [2*PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_buf.sv
// sobel_window_buf: streaming 3x3 window generator for the Sobel kernel.
//   clk, rst     clock, synchronous active-high reset
//   start        begin a frame (only honoured in IDLE)
//   bus          slave side of sobel_window_buf_if (pixels in, windows out)
//   busy         high whenever the FSM is not IDLE
//   frame_done   one-cycle pulse once the last window of a frame has left
// One window per interior pixel, centre (x-1, y-1) of the accepted pixel (x, y).
module sobel_window_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 4,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  sobel_window_buf_if.slave bus,
  output logic busy,
  output logic frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_t               state, state_nxt;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 rdy, acc, last_px, emit;
  logic [2*PIX_W-1:0]   lb_rd;
  // Middle and right columns of the current window, index row*2 + col.
  // The left column is never needed: it falls out on the next shift.
  logic [PIX_W-1:0]     tail_p0 [6];
  logic [PIX_W-1:0]     win_nxt [9];
  logic [9*PIX_W-1:0]   win_flat;
  logic                 vld_p1;
  logic [9*PIX_W-1:0]   out_win_p1;
  logic [XW-1:0]        out_x_p1;
  logic [YW-1:0]        out_y_p1;

  assign acc     = bus.in_valid && rdy;
  assign last_px = (x == X_LAST) && (y == Y_LAST);
  assign emit    = acc && (x >= XW'(2)) && (y >= YW'(2));

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_win   = out_win_p1;
  assign bus.out_x     = out_x_p1;
  assign bus.out_y     = out_y_p1;

  // lb0 in the low half (previous row), lb1 in the high half (two rows back).
  // Each accept ages the column: old lb0 moves to lb1, the new pixel into lb0.
  sobel_line_buf #(
    .PIX_W (PIX_W),
    .DEPTH (IMG_W),
    .AW    (XW)
  ) u_line_buf (
    .clk   (clk),
    .we    (acc),
    .addr  (x),
    .wdata ({lb_rd[PIX_W-1:0], bus.in_pix}),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (acc && last_px) state_nxt = DRAIN;
      DRAIN:   if (!vld_p1 || bus.out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy        = (state == RUN) && (!vld_p1 || bus.out_ready);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (acc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Stage 0: shift the window left, new right column from line buffers + input
  always_comb begin
    for (int k = 0; k < 9; k++) win_nxt[k] = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3]     = tail_p0[r*2];
      win_nxt[r*3 + 1] = tail_p0[r*2 + 1];
    end
    win_nxt[WIN_TR] = lb_rd[2*PIX_W-1:PIX_W];
    win_nxt[WIN_MR] = lb_rd[PIX_W-1:0];
    win_nxt[WIN_BR] = bus.in_pix;
  end

  always_comb begin
    win_flat = '0;
    for (int k = 0; k < 9; k++) win_flat[win_lsb(k, PIX_W) +: PIX_W] = win_nxt[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) tail_p0[i] <= '0;
    end else if (acc) begin
      for (int r = 0; r < 3; r++) begin
        tail_p0[r*2]     <= win_nxt[r*3 + 1];
        tail_p0[r*2 + 1] <= win_nxt[r*3 + 2];
      end
    end
  end

  // Stage 1: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      out_win_p1 <= '0;
      out_x_p1   <= '0;
      out_y_p1   <= '0;
    end else if (emit) begin
      vld_p1     <= 1'b1;
      out_win_p1 <= win_flat;
      out_x_p1   <= x - XW'(1);
      out_y_p1   <= y - YW'(1);
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_buf.sv
// tb_sobel_window_buf: random-stimulus bench for sobel_window_buf.
// Two instances (4x4 and 5x3) share one driver selected by sel; every frame's
// expected windows come from a direct 3x3 neighbourhood walk over the pixel array.
module tb_sobel_window_buf;

  typedef struct packed {
    logic [35:0] win;
    logic [7:0]  x;
    logic [7:0]  y;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic drv_start, drv_valid, drv_ready;
  logic [3:0] drv_pix;
  int   cyc = 0;

  logic start4, start5, busy4, busy5, fd4, fd5;

  sobel_window_buf_if #(.PIX_W(4), .IMG_W(4), .IMG_H(4)) if4 ();
  sobel_window_buf_if #(.PIX_W(4), .IMG_W(5), .IMG_H(3)) if5 ();

  sobel_window_buf #(.PIX_W(4), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bus(if4.slave), .busy(busy4), .frame_done(fd4)
  );
  sobel_window_buf #(.PIX_W(4), .IMG_W(5), .IMG_H(3)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .bus(if5.slave), .busy(busy5), .frame_done(fd5)
  );

  assign start4       = drv_start && !sel;
  assign start5       = drv_start && sel;
  assign if4.in_valid = drv_valid && !sel;
  assign if5.in_valid = drv_valid && sel;
  assign if4.in_pix   = drv_pix;
  assign if5.in_pix   = drv_pix;
  assign if4.out_ready = drv_ready;
  assign if5.out_ready = drv_ready;

  logic        mon_valid, mon_ready, mon_busy, mon_fd;
  logic [35:0] mon_win;
  logic [7:0]  mon_x, mon_y;
  assign mon_valid = sel ? if5.out_valid : if4.out_valid;
  assign mon_ready = sel ? if5.in_ready  : if4.in_ready;
  assign mon_win   = sel ? if5.out_win   : if4.out_win;
  assign mon_x     = sel ? 8'(if5.out_x) : 8'(if4.out_x);
  assign mon_y     = sel ? 8'(if5.out_y) : 8'(if4.out_y);
  assign mon_busy  = sel ? busy5 : busy4;
  assign mon_fd    = sel ? fd5 : fd4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  logic [3:0] pix [64];
  win_t exp_q[$];
  win_t got_q[$];

  always @(negedge clk) begin
    if (mon_valid && drv_ready) got_q.push_back({mon_win, mon_x, mon_y});
    if (mon_fd) fd_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  64'(mon_ready), 0);
    check({tag, "_out_valid"}, 64'(mon_valid), 0);
    check({tag, "_out_win"},   64'(mon_win),   0);
    check({tag, "_out_x"},     64'(mon_x),     0);
    check({tag, "_out_y"},     64'(mon_y),     0);
    check({tag, "_busy"},      64'(mon_busy),  0);
    check({tag, "_frame_done"},64'(mon_fd),    0);
  endtask

  // pat 0: (4y+x) mod 16 ramp, 1: random. spulse: pixel index at which start
  // is pulsed mid-frame (-1 = never). settle: linger after frame_done.
  task automatic run_frame(input int pat, input bit gap, input bit stall,
                           input int spulse, input bit settle);
    int w, h, n, idx, guard, stall_left, last_acc, fd_at;
    bit snap_ok, busy_chk;
    logic [35:0] snap_win;
    logic [7:0]  snap_x, snap_y;
    win_t e;
    w = sel ? 5 : 4;
    h = sel ? 3 : 4;
    n = w * h;
    for (int i = 0; i < n; i++)
      pix[i] = (pat == 0) ? 4'((4 * (i / w) + (i % w)) % 16) : 4'($urandom);
    exp_q.delete();
    for (int cy = 1; cy < h - 1; cy++)
      for (int cx = 1; cx < w - 1; cx++) begin
        e.win = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[(r*3 + c)*4 +: 4] = pix[(cy - 1 + r)*w + (cx - 1 + c)];
        e.x = 8'(cx);
        e.y = 8'(cy);
        exp_q.push_back(e);
      end

    @(posedge clk); #1;
    got_q.delete();
    fd_cnt     = 0;
    stall_left = stall ? 5 : 0;
    snap_ok    = 0;
    busy_chk   = 0;
    last_acc   = 0;
    drv_start  = 1;
    drv_valid  = 0;
    drv_ready  = (stall_left == 0);
    @(posedge clk); #1;
    drv_start = 0;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      drv_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_pix   = drv_valid ? pix[idx] : 4'($urandom);
      drv_start = (idx == spulse) && (spulse >= 0);
      drv_ready = (stall_left == 0);
      @(negedge clk);
      if (!busy_chk) begin
        check("busy_run", 64'(mon_busy), 1);
        busy_chk = 1;
      end
      if (stall_left > 0 && mon_valid) begin
        if (!snap_ok) begin
          snap_win = mon_win; snap_x = mon_x; snap_y = mon_y; snap_ok = 1;
        end else begin
          check("bp_win_hold", 64'(mon_win), 64'(snap_win));
          check("bp_x_hold",   64'(mon_x),   64'(snap_x));
          check("bp_y_hold",   64'(mon_y),   64'(snap_y));
        end
        check("bp_in_ready", 64'(mon_ready), 0);
        stall_left--;
      end
      if (drv_valid && mon_ready) begin
        idx++;
        last_acc = cyc;
        if (idx == spulse) spulse = -1;
      end
      guard++;
      @(posedge clk); #1;
      if (spulse < 0 || idx != spulse) drv_start = 0;
    end
    if (idx < n) check("px_timeout", 64'(idx), 64'(n));
    if (stall) check("bp_seen", 64'(snap_ok), 1);
    drv_valid = 0;
    drv_start = 0;
    drv_ready = 1;
    fd_at = -1;
    for (int g = 0; g < 30 && fd_at < 0; g++) begin
      @(negedge clk);
      if (mon_fd) fd_at = cyc;
    end
    check("fd_seen", 64'(fd_at >= 0), 1);
    if (fd_at >= 0) check("fd_latency", 64'(fd_at - last_acc), 2);
    if (settle) begin
      repeat (3) @(negedge clk);
      check("fd_once",  64'(fd_cnt), 1);
      check("busy_end", 64'(mon_busy), 0);
    end
    check("win_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("win[%0d]", i), 64'(got_q[i].win), 64'(exp_q[i].win));
      check($sformatf("x[%0d]", i),   64'(got_q[i].x),   64'(exp_q[i].x));
      check($sformatf("y[%0d]", i),   64'(got_q[i].y),   64'(exp_q[i].y));
    end
  endtask

  // Start a 4x4 frame, feed npx pixels, then reset mid-frame.
  task automatic rst_mid(input int npx, input bit rdy);
    int idx, guard;
    sel = 0;
    @(posedge clk); #1;
    drv_start = 1;
    drv_ready = rdy;
    @(posedge clk); #1;
    drv_start = 0;
    idx = 0;
    guard = 0;
    while (idx < npx && guard < 200) begin
      drv_valid = 1;
      drv_pix   = 4'($urandom);
      @(negedge clk);
      if (mon_ready) idx++;
      guard++;
      @(posedge clk); #1;
    end
    drv_valid = 0;
    @(negedge clk);
    if (!rdy) check("pending_window", 64'(mon_valid), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    drv_ready = 1;
    @(negedge clk);
    check_idle($sformatf("rst_mid%0d", npx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] w_first, w_last;
    w_first = {4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2, 4'd1, 4'd0};
    w_last  = {4'd15, 4'd14, 4'd13, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5};
    sel = 0; rst = 1;
    drv_start = 0; drv_valid = 0; drv_ready = 1; drv_pix = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset");

    run_frame(0, 0, 0, -1, 1);
    if (got_q.size() >= 4) begin
      check("first_win", 64'(got_q[0].win), 64'(w_first));
      check("first_x",   64'(got_q[0].x), 1);
      check("first_y",   64'(got_q[0].y), 1);
      check("last_win",  64'(got_q[3].win), 64'(w_last));
      check("last_x",    64'(got_q[3].x), 2);
      check("last_y",    64'(got_q[3].y), 2);
    end
    run_frame(0, 0, 1, -1, 1);
    run_frame(0, 1, 0, -1, 1);
    run_frame(1, 1, 0, -1, 1);

    sel = 1;
    run_frame(1, 0, 0, -1, 1);
    if (got_q.size() >= 3) begin
      check("np2_c0_x", 64'(got_q[0].x), 1);
      check("np2_c1_x", 64'(got_q[1].x), 2);
      check("np2_c2_x", 64'(got_q[2].x), 3);
      check("np2_c2_y", 64'(got_q[2].y), 1);
    end
    run_frame(0, 1, 0, -1, 1);
    run_frame(1, 0, 1, -1, 1);

    sel = 0;
    run_frame(1, 0, 0, 5, 1);
    rst_mid(9, 1);
    rst_mid(11, 0);
    run_frame(1, 0, 0, -1, 1);

    run_frame(1, 0, 0, -1, 0);
    run_frame(1, 1, 0, -1, 0);
    run_frame(1, 0, 0, -1, 1);
    sel = 1;
    run_frame(1, 0, 0, -1, 0);
    run_frame(1, 1, 0, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_window_buf.md
Name: sobel_window_buf

Overview:
Parametrised streaming 3x3 window generator between the grayscale stage and the Sobel kernel. It replaces fixed-size address-generator/memOp sequencing with a raster-order pixel stream, two line buffers and a 3x3 register window. Every interior pixel yields one window, plus centre coordinates, over a valid/ready handshake with full back-pressure. Frame framing (start / frame_done) replaces the separate gen_done/sobel_done FSM handoff.

Parameters:
PIX_W, 4, bits per grayscale pixel
IMG_W, 32, image width in pixels (>=3)
IMG_H, 32, image height in pixels (>=3)
XW, $clog2(IMG_W), column counter width (derived, not overridden)
YW, $clog2(IMG_H), row counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin frame; honoured only in IDLE
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts pixel this cycle
in_pix  in  PIX_W  grayscale pixel, raster order
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
out_win  out  9*PIX_W  window; element k at [k*PIX_W +: PIX_W], k=row*3+col, row 0 = oldest line
out_x  out  XW  window centre column
out_y  out  YW  window centre row
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state=IDLE; in_ready=0, out_valid=0, out_win=0, out_x=0, out_y=0, busy=0, frame_done=0. Window registers and counters clear. Line-buffer RAM is not cleared; the first two rows overwrite it before use.
- States: IDLE -> RUN on start. RUN -> DRAIN when the pixel at (IMG_W-1, IMG_H-1) is accepted. DRAIN -> DONE when out_valid=0, or out_valid&&out_ready. DONE -> IDLE unconditionally; frame_done=1 only in DONE.
- start is ignored outside IDLE. A start asserted in IDLE clears x/y counters the same cycle.
- in_ready = (state==RUN) && (!out_valid || out_ready). Accept = in_valid && in_ready. No pixel is accepted in IDLE, DRAIN or DONE.
- Accept at (x,y):
  - Column x of lb1 is loaded with the old lb0[x], and lb0[x] is loaded with in_pix. Reads happen before writes.
  - The window shifts left one column. The new right column is {lb1[x], lb0[x], in_pix} for rows 0, 1, 2.
  - x increments and wraps to 0 at IMG_W-1; y increments on that wrap.
- Output: an accept with x>=2 and y>=2 loads out_win/out_x/out_y with centre (x-1, y-1) and sets out_valid=1 on the next cycle (latency 1).
- Output clear: out_valid clears on out_valid&&out_ready when no new window loads the same cycle. Simultaneous handshake plus new load keeps out_valid=1 with the new data.
- Hold: while out_valid&&!out_ready, out_win, out_x and out_y stay stable.
- Row boundaries: the window is not flushed at a row start. Accepts with x<2 shift in stale columns and produce no output.
- Window count per frame = (IMG_W-2)*(IMG_H-2).
- Counters wrap at IMG_W-1 / IMG_H-1, never at 2^XW. Non-power-of-2 sizes must work.
- rst mid-frame: immediate return to reset values; any pending window is discarded; a new start is required.
- in_pix is a don't-care when in_valid=0; gaps in in_valid must not affect the result.

Decomposition:
- Shared package sobel_pkg: state enum {IDLE, RUN, DRAIN, DONE}, window index constants (WIN_TL..WIN_BR = 0..8), and a function for window element slicing.
- Sub-module sobel_line_buf: depth IMG_W, width 2*PIX_W (lb0 and lb1 packed), combinational read, synchronous write, read-before-write on the same address.
- FSM, counters and window registers live in the top module.

Test Plan:
- Basic 4x4 frame (PIX_W=4, IMG_W=4, IMG_H=4, pixel=(4y+x) mod 16, out_ready=1): start, stream 16 pixels.
  - 1st window has out_x=1, out_y=1, elements 0,1,2,4,5,6,8,9,10.
  - Exactly 4 windows total; last window centre (2,2) = 5,6,7,9,10,11,13,14,15.
  - frame_done pulses once, 2 cycles after the last accept.
- Back-pressure: same frame with out_ready held 0 for 5 cycles at the first window.
  - out_valid stays 1 with the window stable and in_ready=0.
  - No pixel is lost; the window sequence is identical to the basic case.
- Input gaps: random in_valid deassertion (~50%) -> output sequence identical to the basic case.
- Non-power-of-2 frame (IMG_W=5, IMG_H=3): stream 15 pixels.
  - 3 windows at centres (1,1), (2,1), (3,1).
  - Counter wraps at 4; frame_done fires.
- Control robustness:
  - start pulsed during RUN -> ignored, counters unaffected.
  - rst asserted after 9 pixels -> all outputs 0 next cycle, state IDLE.
  - A new full frame then produces correct windows.
- Back-to-back frames: start asserted in the cycle after frame_done -> the second frame's windows match the reference model; no stale first-frame data appears in any valid window.
